// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM arbiter: requester ids and the
// read-return tracking entry.
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } ret_entry_t;

endpackage

// File: rtl/ram_arb_rdpipe.sv
// Read-return tracker: shifts {valid, id} alongside the RAM read latency
// and decodes the tail entry into per-requester rvalid strobes.
module ram_arb_rdpipe
  import ram_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    push,
  input  req_id_t id,
  output logic    rvalid0,
  output logic    rvalid1
);

  ret_entry_t pipe [0:RD_LAT];

  // Stage 0 holds the read accepted on the last edge; the tail lines up with ram_q.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: push, id: id};
      for (int i = 1; i <= RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign rvalid0 = pipe[RD_LAT].valid && (pipe[RD_LAT].id == REQ_CPU);
  assign rvalid1 = pipe[RD_LAT].valid && (pipe[RD_LAT].id == REQ_DMA);

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a single-port synchronous RAM: zero-wait grant,
// fixed CPU priority or round-robin, in-order tagged read returns.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_prio,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  req_id_t last_winner;
  req_id_t win_id;
  logic    accept;
  logic    win_we;

  // Grants are held low during reset so nothing is accepted on that edge.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        if (cpu_prio || (last_winner == REQ_DMA)) gnt0 = 1'b1;
        else                                      gnt1 = 1'b1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign accept = gnt0 | gnt1;
  assign win_id = gnt1 ? REQ_DMA : REQ_CPU;
  assign win_we = gnt1 ? we1 : we0;

  // RAM port register: address/data hold when idle, write enable pulses only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_winner <= REQ_DMA;
      ram_wren    <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
    end else begin
      ram_wren <= 1'b0;
      if (accept) begin
        last_winner <= win_id;
        ram_wren    <= win_we;
        ram_address <= gnt1 ? addr1 : addr0;
        ram_data    <= gnt1 ? wdata1 : wdata0;
      end
    end
  end

  ram_arb_rdpipe #(
    .RD_LAT(RD_LAT)
  ) u_rdpipe (
    .clock  (clock),
    .reset  (reset),
    .push   (accept && !win_we),
    .id     (win_id),
    .rvalid0(rvalid0),
    .rvalid1(rvalid1)
  );

  assign rdata = ram_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: two arbiters (RD_LAT=1 and RD_LAT=3) share one set of
// requests, each backed by its own synchronous RAM model.
module tb_ram_arbiter;

  logic        clock;
  logic        reset;
  logic        cpu_prio;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, wdata0, addr1, wdata1;

  logic        gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, ram_wren_a;
  logic [15:0] rdata_a, ram_address_a, ram_data_a, ram_q_a;
  logic        gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, ram_wren_b;
  logic [15:0] rdata_b, ram_address_b, ram_data_b, ram_q_b;

  logic        pre_en;
  logic [15:0] pre_addr, pre_data;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1)) dut_a (
    .clock(clock), .reset(reset), .cpu_prio(cpu_prio),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0_a), .rvalid0(rvalid0_a),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1_a), .rvalid1(rvalid1_a),
    .rdata(rdata_a), .ram_address(ram_address_a), .ram_data(ram_data_a),
    .ram_wren(ram_wren_a), .ram_q(ram_q_a)
  );

  ram_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(3)) dut_b (
    .clock(clock), .reset(reset), .cpu_prio(cpu_prio),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0_b), .rvalid0(rvalid0_b),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1_b), .rvalid1(rvalid1_b),
    .rdata(rdata_b), .ram_address(ram_address_b), .ram_data(ram_data_b),
    .ram_wren(ram_wren_b), .ram_q(ram_q_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM models: one-edge read for dut_a, three-edge read for dut_b.
  logic [15:0] mem_a [0:65535];
  logic [15:0] mem_b [0:65535];
  logic [15:0] qb [0:2];

  always @(posedge clock) begin
    if (pre_en)          mem_a[pre_addr] <= pre_data;
    else if (ram_wren_a) mem_a[ram_address_a] <= ram_data_a;
    ram_q_a <= mem_a[ram_address_a];
  end

  always @(posedge clock) begin
    if (pre_en)          mem_b[pre_addr] <= pre_data;
    else if (ram_wren_b) mem_b[ram_address_b] <= ram_data_b;
    qb[0] <= mem_b[ram_address_b];
    qb[1] <= qb[0];
    qb[2] <= qb[1];
  end
  assign ram_q_b = qb[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set0(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    req0 = r; we0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    req1 = r; we1 = w; addr1 = a; wdata1 = d;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic idle(input int n);
    set0(1'b0, 1'b0, 16'h0, 16'h0);
    set1(1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1; cpu_prio = 1'b0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    set0(1'b1, 1'b0, 16'h0010, 16'h0);
    set1(1'b1, 1'b0, 16'h0020, 16'h0);
    #2;
    check("rst_gnt0", gnt0_a, 0);
    check("rst_gnt1", gnt1_a, 0);
    check("rst_wren", ram_wren_a, 0);
    check("rst_addr", ram_address_a, 0);
    check("rst_data", ram_data_a, 0);
    check("rst_rvalid", {rvalid0_a, rvalid1_a, rvalid0_b, rvalid1_b}, 0);
    set0(1'b0, 1'b0, 16'h0, 16'h0);
    set1(1'b0, 1'b0, 16'h0, 16'h0);
    preload(16'h0010, 16'hBEEF);
    preload(16'h0020, 16'h1111);
    preload(16'h0021, 16'h2222);
    preload(16'h0022, 16'h3333);
    reset = 1'b0;

    // Lone CPU read, accepted on the first edge after reset release.
    set0(1'b1, 1'b0, 16'h0010, 16'h0);
    #1;
    check("lone_gnt0", gnt0_a, 1);
    check("lone_gnt1", gnt1_a, 0);
    tick();
    set0(1'b0, 1'b0, 16'h0, 16'h0);
    check("lone_addr", ram_address_a, 16'h0010);
    check("lone_rv_early", rvalid0_a, 0);
    tick();
    check("lone_rv_a", rvalid0_a, 1);
    check("lone_rdata_a", rdata_a, 16'hBEEF);
    check("lone_rv1_a", rvalid1_a, 0);
    tick();
    check("lone_rv_a_once", rvalid0_a, 0);
    check("lone_rv_b_early", rvalid0_b, 0);
    tick();
    check("lone_rv_b", rvalid0_b, 1);
    check("lone_rdata_b", rdata_b, 16'hBEEF);
    tick();
    check("lone_rv_b_once", rvalid0_b, 0);

    // Alternating single-requester reads 0,1,0 on consecutive cycles.
    set0(1'b1, 1'b0, 16'h0020, 16'h0);
    #1;
    check("alt_gntA", gnt0_a, 1);
    tick();
    set0(1'b0, 1'b0, 16'h0, 16'h0);
    set1(1'b1, 1'b0, 16'h0021, 16'h0);
    #1;
    check("alt_gntB", gnt1_a, 1);
    tick();
    check("alt_a0", {rvalid0_a, rvalid1_a}, 2'b10);
    check("alt_a0_data", rdata_a, 16'h1111);
    set1(1'b0, 1'b0, 16'h0, 16'h0);
    set0(1'b1, 1'b0, 16'h0022, 16'h0);
    tick();
    check("alt_a1", {rvalid0_a, rvalid1_a}, 2'b01);
    check("alt_a1_data", rdata_a, 16'h2222);
    set0(1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    check("alt_a2", {rvalid0_a, rvalid1_a}, 2'b10);
    check("alt_a2_data", rdata_a, 16'h3333);
    check("alt_b0", {rvalid0_b, rvalid1_b}, 2'b10);
    check("alt_b0_data", rdata_b, 16'h1111);
    tick();
    check("alt_a_done", {rvalid0_a, rvalid1_a}, 2'b00);
    check("alt_b1", {rvalid0_b, rvalid1_b}, 2'b01);
    check("alt_b1_data", rdata_b, 16'h2222);
    tick();
    check("alt_b2", {rvalid0_b, rvalid1_b}, 2'b10);
    check("alt_b2_data", rdata_b, 16'h3333);
    tick();
    check("alt_b_done", {rvalid0_b, rvalid1_b}, 2'b00);

    // DMA write then CPU read of the same address.
    set1(1'b1, 1'b1, 16'h0200, 16'h1234);
    #1;
    check("wr_gnt1", gnt1_a, 1);
    tick();
    check("wr_wren", ram_wren_a, 1);
    check("wr_addr", ram_address_a, 16'h0200);
    check("wr_data", ram_data_a, 16'h1234);
    set1(1'b0, 1'b0, 16'h0, 16'h0);
    set0(1'b1, 1'b0, 16'h0200, 16'h0);
    #1;
    check("rd_gnt0", gnt0_a, 1);
    tick();
    check("wr_wren_once", ram_wren_a, 0);
    check("wr_rv_none", {rvalid0_a, rvalid1_a}, 2'b00);
    set0(1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    check("raw_rv_a", {rvalid0_a, rvalid1_a}, 2'b10);
    check("raw_data_a", rdata_a, 16'h1234);
    tick();
    tick();
    check("raw_rv_b", {rvalid0_b, rvalid1_b}, 2'b10);
    check("raw_data_b", rdata_b, 16'h1234);
    tick();

    // Fixed CPU priority, then round-robin hands the next cycle to DMA.
    cpu_prio = 1'b1;
    set0(1'b1, 1'b0, 16'h0300, 16'h0);
    set1(1'b1, 1'b0, 16'h0301, 16'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("prio_gnt0", gnt0_a, 1);
      check("prio_gnt1", gnt1_a, 0);
      tick();
    end
    cpu_prio = 1'b0;
    #1;
    check("prio_drop_gnt1", gnt1_a, 1);
    check("prio_drop_gnt0", gnt0_a, 0);
    tick();
    check("prio_drop_addr", ram_address_a, 16'h0301);
    idle(6);

    // Round-robin from reset: CPU first, then strict alternation.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set0(1'b1, 1'b0, 16'h0100, 16'h0);
    set1(1'b1, 1'b0, 16'h0101, 16'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_gnt0", gnt0_a, (i % 2 == 0) ? 1 : 0);
      check("rr_gnt1", gnt1_a, (i % 2 == 1) ? 1 : 0);
      tick();
      check("rr_addr", ram_address_a, (i % 2 == 0) ? 16'h0100 : 16'h0101);
    end
    idle(6);

    // Reset arriving while a read is in flight drops its return.
    set0(1'b1, 1'b0, 16'h0010, 16'hAAAA);
    tick();
    check("mid_data_pre", ram_data_a, 16'hAAAA);
    reset = 1'b1;
    set1(1'b1, 1'b0, 16'h0011, 16'h0);
    #1;
    check("mid_gnt", {gnt0_a, gnt1_a}, 2'b00);
    check("mid_addr", ram_address_a, 0);
    check("mid_data", ram_data_a, 0);
    check("mid_wren", ram_wren_a, 0);
    tick();
    check("mid_rv_a", {rvalid0_a, rvalid1_a}, 2'b00);
    set0(1'b0, 1'b0, 16'h0, 16'h0);
    set1(1'b0, 1'b0, 16'h0, 16'h0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_rv_after", {rvalid0_a, rvalid1_a, rvalid0_b, rvalid1_b}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 16, RAM address width; DATA_W, 16, RAM data width; RD_LAT, 1, RAM clock-edges from address capture to valid ram_q (1..4).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clock  in  1  single clock, rising edge; same clock as the RAM port it drives
  reset  in  1  asynchronous, active-high reset
  cpu_prio  in  1  1 = requester 0 has fixed priority; 0 = round-robin
  req0  in  1  requester 0 (CPU) access request
  we0  in  1  requester 0 write enable (0 = read)
  addr0  in  ADDR_W  requester 0 address
  wdata0  in  DATA_W  requester 0 write data
  gnt0  out  1  requester 0 granted this cycle
  rvalid0  out  1  read data for requester 0 valid on rdata
  req1, we1, addr1, wdata1, gnt1, rvalid1  same as above for requester 1 (DMA/blitter)
  rdata  out  DATA_W  read data, equal to ram_q, qualified by rvalid0/rvalid1
  ram_address  out  ADDR_W  to RAM address port
  ram_data  out  DATA_W  to RAM write-data port
  ram_wren  out  1  to RAM write enable
  ram_q  in  DATA_W  from RAM read-data port
REQ-003 The design SHALL use one clock; reset SHALL be asynchronous and active-high, as already decided.

Function
REQ-004 gntN SHALL be combinational from reqN, the other req, cpu_prio and the last-winner register; at most one gnt high per cycle; gntN never high without reqN.
REQ-005 An access SHALL be accepted on the rising edge where reqN && gntN; requester holds req/we/addr/wdata stable until that edge.
REQ-006 Single requester SHALL be granted in the same cycle (zero wait); throughput one access per cycle.
REQ-007 Both requesting, cpu_prio=1: gnt0 SHALL win.
REQ-008 Both requesting, cpu_prio=0: the requester not in last_winner SHALL win; last_winner updates only on an accepted access.
REQ-009 On acceptance, ram_address/ram_data/ram_wren SHALL register addr/wdata/we of the winner; on a cycle with no acceptance ram_wren SHALL register 0 and ram_address/ram_data hold.
REQ-010 For an accepted read, rvalidN SHALL be high for exactly one cycle, RD_LAT+1 cycles after the acceptance edge; writes SHALL produce no rvalid.
REQ-011 Read returns SHALL come in acceptance order; back-to-back reads from alternating requesters SHALL each return with correct ID; rvalid0 and rvalid1 never both high.
REQ-012 Read-return tracking SHALL be an RD_LAT+1-deep shift register of {valid, id}; no backpressure on returns.
REQ-013 Write followed by read to same address on the next accepted cycle SHALL return the new data (RAM old/new behaviour not relied on; ordering by RAM edges suffices for RD_LAT>=1).

Reset
REQ-014 While reset high: gnt0=gnt1=0, rvalid0=rvalid1=0, ram_wren=0, ram_address=0, ram_data=0, return pipeline cleared, last_winner=1 (so requester 0 wins the first round-robin tie).
REQ-015 Reads in flight at reset assertion SHALL be dropped; no rvalid after reset release for them.
REQ-016 First acceptance possible on the first rising edge after reset deasserts.

Structure
REQ-017 Package ram_arb_pkg SHALL hold default ADDR_W/DATA_W, the requester-id typedef (REQ_CPU=0, REQ_DMA=1) and the return-pipeline entry struct {valid, id}.
REQ-018 Sub-module ram_arb_rdpipe SHALL implement the RD_LAT+1 return shift register and rvalid decode; grant logic stays in ram_arbiter.

Verification
REQ-019 Reset mid-read: read accepted at cycle 5, reset at cycle 6 -> no rvalid0 at cycle 7, all outputs 0 during reset.
REQ-020 Lone CPU read addr0=0x0010, RAM[0x10]=0xBEEF, RD_LAT=1 -> gnt0 same cycle, ram_address=0x0010 next cycle, rvalid0 with rdata=0xBEEF 2 cycles after acceptance.
REQ-021 Both requesting continuously, cpu_prio=0 -> grants alternate 0,1,0,1 starting with 0 after reset; ram_address alternates addr0/addr1.
REQ-022 Both requesting, cpu_prio=1 for 4 cycles -> gnt0 four times, gnt1 never; drop cpu_prio -> gnt1 next cycle.
REQ-023 DMA write addr1=0x0200 data 0x1234, then CPU read 0x0200 next cycle -> ram_wren=1 one cycle only, rvalid0 with rdata=0x1234, no rvalid1.
REQ-024 RD_LAT=3, alternating reads 0,1,0 -> rvalid0,rvalid1,rvalid0 on consecutive cycles starting 4 cycles after first acceptance.
